core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle control FSM for the non-pipelined core. It sequences fetch, decode, execute, memory access, write-back and trap entry around the instruction decoder, register file, ALU and bus interfaces. It consumes the decoder's opcode and class flags and drives every enable and select of the datapath. It owns bus-wait timeout detection for both buses.

## Interface
- BUS_TIMEOUT, 15: maximum wait cycles on either bus before an access-fault trap; legal range 1-255.
- i_clock  in  1  core clock; all state changes on its rising edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_instOP  in  7  OpCode from the decoder.
- i_isIllegal, i_isALU, i_isECALL, i_isEBREAK, i_isCSR  in  1 each  decoder class flags.
- i_branchTaken  in  1  branch comparator result for the current instruction.
- i_ibusReady  in  1  instruction bus accepts/returns the word this cycle.
- i_dbusReady  in  1  data bus completes the access this cycle.
- o_ibusRd  out  1  instruction read request.
- o_instLoad  out  1  load the instruction register.
- o_dbusRd, o_dbusWr  out  1 each  data read/write request.
- o_regWrEnable  out  1  register file write strobe.
- o_wrDataSel  out  2  write-back source: 0 ALU, 1 MEM, 2 PC+4, 3 CSR.
- o_csrWr  out  1  CSR write strobe.
- o_pcUpdate  out  1  PC register load enable.
- o_pcSel  out  2  next PC: 0 PC+4, 1 PC+imm, 2 (rs1+imm)&~1, 3 trap vector.
- o_trap  out  1  trap entry pulse; latches mepc/mcause.
- o_trapCause  out  4  mcause code, valid while o_trap.
- o_state  out  3  current state, for debug.

## Operation
- States: FETCH(0), DECODE(1), EXECUTE(2), MEMORY(3), WRITEBACK(4), TRAP(5). Outputs are a Moore decode of the state register, plus the ready inputs as noted.
- FETCH: o_ibusRd=1. If i_ibusReady=1: o_instLoad=1 in the same cycle, then go to DECODE. Otherwise increment the wait counter.
- DECODE: single cycle for the decoder and register-file read. If i_isIllegal, i_isECALL or i_isEBREAK, go to TRAP. Otherwise go to EXECUTE.
- EXECUTE, by i_instOP:
  - Load/Store: go to MEMORY.
  - Branch: o_pcUpdate=1, o_pcSel = i_branchTaken ? 1 : 0, go to FETCH.
  - JAL, JALR, LUI, AUIPC, ALU ops, CSR ops: go to WRITEBACK.
- MEMORY: o_dbusRd (Load) or o_dbusWr (Store) held until i_dbusReady.
  - Load completes: go to WRITEBACK with source MEM.
  - Store completes: o_pcUpdate=1, o_pcSel=0, go to FETCH.
- WRITEBACK: o_regWrEnable=1 and o_pcUpdate=1 for one cycle, then go to FETCH.
  - Write-back source: JAL/JALR→2; CSR→3 with o_csrWr=1; Load→1; otherwise 0.
  - o_pcSel: JAL→1, JALR→2, otherwise 0.
- TRAP: o_trap=1, o_pcUpdate=1, o_pcSel=3, go to FETCH. Causes:
  - instruction access fault 1
  - illegal instruction 2
  - EBREAK 3
  - load access fault 5
  - store access fault 7
  - ECALL 11
- Decode-fault priority: illegal > EBREAK > ECALL.
- Wait counter: 8 bits. Cleared on every entry to FETCH or MEMORY. Increments each cycle that ready is low. When the counter equals BUS_TIMEOUT with ready still low, drop the request and go to TRAP with cause 1 (FETCH) or 5/7 (MEMORY). Ready asserted in that same cycle wins.
- Register writes and bus requests are never asserted in TRAP.

## Timing
- Reset values, with i_reset sampled high and the cycle after: state FETCH, counter 0. All strobes 0 while i_reset=1, including o_ibusRd; o_pcSel=0, o_wrDataSel=0, o_trapCause=0.
- Reset mid-access abandons the access: next cycle is FETCH with a fresh request. No write-back or trap occurs.
- Cycles per instruction with zero-wait buses (ready in the first request cycle):
  - branch: 3
  - ALU, LUI, AUIPC, JAL, JALR, CSR: 4
  - store: 4
  - load: 5
  - trap: 3
- Each bus wait cycle adds 1.
- A timeout trap occurs BUS_TIMEOUT+1 cycles after the request first asserts.
- Decoder inputs are sampled only in DECODE and EXECUTE; the instruction register keeps them stable.

## Structure
- Types package additions:
  - CtrlState enum (3 bits)
  - PcSel enum: PcSel_Next, PcSel_Offset, PcSel_Reg, PcSel_Trap
  - WrDataSel enum: WrDataSel_ALU, WrDataSel_MEM, WrDataSel_PC4, WrDataSel_CSR
  - TrapCause constants: 1, 2, 3, 5, 7, 11
- One sub-module, bus_wait_timer.
  - Inputs: clear, waiting, ready.
  - Output: timeout.
  - Parameter: BUS_TIMEOUT.
  - Instantiated once; shared between FETCH and MEMORY, which never overlap.

## Test plan
- ADDI, zero-wait ibus → states 0,1,2,4,0; o_regWrEnable high exactly 1 cycle, o_wrDataSel=0, o_pcSel=0.
- LW, dbus ready after 3 wait cycles → o_dbusRd high 4 cycles, then WRITEBACK with o_wrDataSel=1; 8 cycles total.
- BEQ with i_branchTaken=1, then 0 → o_pcSel=1 then 0, o_pcUpdate in EXECUTE, no register write, 3 cycles each.
- Illegal word, then EBREAK, then ECALL → TRAP with o_trapCause 2, 3, 11; o_pcSel=3; o_regWrEnable never high.
- i_ibusReady held low, BUS_TIMEOUT=15 → o_trap 16 cycles after request start with cause 1. Repeat with ready arriving at count 15 → no trap.
- i_reset pulsed during MEMORY of SW → o_dbusWr drops the same cycle; state FETCH next; no o_pcUpdate.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the multi-cycle core control sequencer.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        CtrlState_Fetch     = 3'd0,
        CtrlState_Decode    = 3'd1,
        CtrlState_Execute   = 3'd2,
        CtrlState_Memory    = 3'd3,
        CtrlState_Writeback = 3'd4,
        CtrlState_Trap      = 3'd5
    } CtrlState;

    typedef enum logic [1:0] {
        PcSel_Next   = 2'd0,
        PcSel_Offset = 2'd1,
        PcSel_Reg    = 2'd2,
        PcSel_Trap   = 2'd3
    } PcSel;

    typedef enum logic [1:0] {
        WrDataSel_ALU = 2'd0,
        WrDataSel_MEM = 2'd1,
        WrDataSel_PC4 = 2'd2,
        WrDataSel_CSR = 2'd3
    } WrDataSel;

    // mcause codes
    localparam logic [3:0] TRAP_INST_ACCESS  = 4'd1;
    localparam logic [3:0] TRAP_ILLEGAL      = 4'd2;
    localparam logic [3:0] TRAP_BREAKPOINT   = 4'd3;
    localparam logic [3:0] TRAP_LOAD_ACCESS  = 4'd5;
    localparam logic [3:0] TRAP_STORE_ACCESS = 4'd7;
    localparam logic [3:0] TRAP_ECALL_M      = 4'd11;

    // RV32I major opcodes the sequencer distinguishes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // True when the instruction finishes through the register write-back step
    function automatic logic writes_back(input logic [6:0] op, input logic is_alu, input logic is_csr);
        return (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI) ||
               (op == OP_AUIPC) || is_alu || is_csr;
    endfunction

endpackage

// File: rtl/core_sequencer_bus_wait_timer.sv
// Wait-cycle counter shared by the instruction and data bus phases.
// Raises timeout in the cycle the count reaches BUS_TIMEOUT with ready still low.
module bus_wait_timer #(
    parameter int BUS_TIMEOUT = 15
) (
    input  logic i_clock,
    input  logic clear,
    input  logic waiting,
    input  logic ready,
    output logic timeout
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(BUS_TIMEOUT);

    logic [7:0] count_r;

    // Count consecutive not-ready request cycles; restart whenever the wait ends
    always_ff @(posedge i_clock) begin
        if (clear) begin
            count_r <= 8'd0;
        end else if (waiting && !ready) begin
            if (count_r != 8'hFF) begin
                count_r <= count_r + 8'd1;
            end else begin
                count_r <= count_r;
            end
        end else begin
            count_r <= 8'd0;
        end
    end

    assign timeout = waiting && !ready && (count_r == TIMEOUT_LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, write-back and trap entry.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int BUS_TIMEOUT = 15
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [6:0] i_instOP,
    input  logic       i_isIllegal,
    input  logic       i_isALU,
    input  logic       i_isECALL,
    input  logic       i_isEBREAK,
    input  logic       i_isCSR,
    input  logic       i_branchTaken,
    input  logic       i_ibusReady,
    input  logic       i_dbusReady,
    output logic       o_ibusRd,
    output logic       o_instLoad,
    output logic       o_dbusRd,
    output logic       o_dbusWr,
    output logic       o_regWrEnable,
    output logic [1:0] o_wrDataSel,
    output logic       o_csrWr,
    output logic       o_pcUpdate,
    output logic [1:0] o_pcSel,
    output logic       o_trap,
    output logic [3:0] o_trapCause,
    output logic [2:0] o_state
);

    CtrlState   state_r;
    logic [3:0] cause_r;
    // Instruction facts captured in EXECUTE; decoder inputs are not trusted afterwards
    logic       is_load_r;
    logic       is_store_r;
    logic       is_jal_r;
    logic       is_jalr_r;
    logic       is_csr_r;

    logic op_load_s;
    logic op_store_s;
    logic op_branch_s;
    logic op_wb_s;
    logic waiting_s;
    logic ready_s;
    logic clear_s;
    logic timeout_s;

    assign op_load_s   = (i_instOP == OP_LOAD);
    assign op_store_s  = (i_instOP == OP_STORE);
    assign op_branch_s = (i_instOP == OP_BRANCH);
    assign op_wb_s     = writes_back(i_instOP, i_isALU, i_isCSR);

    // FETCH and MEMORY never overlap, so one timer serves both buses
    assign waiting_s = (state_r == CtrlState_Fetch) || (state_r == CtrlState_Memory);
    assign ready_s   = (state_r == CtrlState_Fetch) ? i_ibusReady : i_dbusReady;
    assign clear_s   = i_reset || (waiting_s && (ready_s || timeout_s));

    bus_wait_timer #(
        .BUS_TIMEOUT(BUS_TIMEOUT)
    ) u_bus_wait_timer (
        .i_clock (i_clock),
        .clear   (clear_s),
        .waiting (waiting_s),
        .ready   (ready_s),
        .timeout (timeout_s)
    );

    // State register plus the per-instruction facts carried past EXECUTE
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r    <= CtrlState_Fetch;
            cause_r    <= 4'd0;
            is_load_r  <= 1'b0;
            is_store_r <= 1'b0;
            is_jal_r   <= 1'b0;
            is_jalr_r  <= 1'b0;
            is_csr_r   <= 1'b0;
        end else begin
            case (state_r)
                CtrlState_Fetch: begin
                    if (i_ibusReady) begin
                        state_r <= CtrlState_Decode;
                    end else if (timeout_s) begin
                        state_r <= CtrlState_Trap;
                        cause_r <= TRAP_INST_ACCESS;
                    end else begin
                        state_r <= CtrlState_Fetch;
                    end
                end
                CtrlState_Decode: begin
                    if (i_isIllegal) begin
                        state_r <= CtrlState_Trap;
                        cause_r <= TRAP_ILLEGAL;
                    end else if (i_isEBREAK) begin
                        state_r <= CtrlState_Trap;
                        cause_r <= TRAP_BREAKPOINT;
                    end else if (i_isECALL) begin
                        state_r <= CtrlState_Trap;
                        cause_r <= TRAP_ECALL_M;
                    end else begin
                        state_r <= CtrlState_Execute;
                    end
                end
                CtrlState_Execute: begin
                    is_load_r  <= op_load_s;
                    is_store_r <= op_store_s;
                    is_jal_r   <= (i_instOP == OP_JAL);
                    is_jalr_r  <= (i_instOP == OP_JALR);
                    is_csr_r   <= i_isCSR;
                    if (op_load_s || op_store_s) begin
                        state_r <= CtrlState_Memory;
                    end else if (op_branch_s) begin
                        state_r <= CtrlState_Fetch;
                    end else if (op_wb_s) begin
                        state_r <= CtrlState_Writeback;
                    end else begin
                        // Nothing to write (e.g. FENCE): just advance the PC
                        state_r <= CtrlState_Fetch;
                    end
                end
                CtrlState_Memory: begin
                    if (i_dbusReady) begin
                        state_r <= is_load_r ? CtrlState_Writeback : CtrlState_Fetch;
                    end else if (timeout_s) begin
                        state_r <= CtrlState_Trap;
                        cause_r <= is_load_r ? TRAP_LOAD_ACCESS : TRAP_STORE_ACCESS;
                    end else begin
                        state_r <= CtrlState_Memory;
                    end
                end
                CtrlState_Writeback: state_r <= CtrlState_Fetch;
                CtrlState_Trap:      state_r <= CtrlState_Fetch;
                default:             state_r <= CtrlState_Fetch;
            endcase
        end
    end

    // Datapath controls: Moore decode of the state plus bus-ready handshakes, silenced in reset
    always_comb begin
        o_ibusRd      = 1'b0;
        o_instLoad    = 1'b0;
        o_dbusRd      = 1'b0;
        o_dbusWr      = 1'b0;
        o_regWrEnable = 1'b0;
        o_wrDataSel   = WrDataSel_ALU;
        o_csrWr       = 1'b0;
        o_pcUpdate    = 1'b0;
        o_pcSel       = PcSel_Next;
        o_trap        = 1'b0;
        o_trapCause   = 4'd0;
        o_state       = CtrlState_Fetch;
        if (i_reset) begin
            o_state = CtrlState_Fetch;
        end else begin
            o_state = state_r;
            case (state_r)
                CtrlState_Fetch: begin
                    o_ibusRd   = 1'b1;
                    o_instLoad = i_ibusReady;
                end
                CtrlState_Execute: begin
                    if (op_branch_s) begin
                        o_pcUpdate = 1'b1;
                        o_pcSel    = i_branchTaken ? PcSel_Offset : PcSel_Next;
                    end else if (!(op_load_s || op_store_s || op_wb_s)) begin
                        o_pcUpdate = 1'b1;
                    end else begin
                        o_pcUpdate = 1'b0;
                    end
                end
                CtrlState_Memory: begin
                    o_dbusRd   = is_load_r;
                    o_dbusWr   = is_store_r;
                    o_pcUpdate = is_store_r && i_dbusReady;
                end
                CtrlState_Writeback: begin
                    o_regWrEnable = 1'b1;
                    o_pcUpdate    = 1'b1;
                    o_csrWr       = is_csr_r;
                    if (is_jal_r || is_jalr_r) begin
                        o_wrDataSel = WrDataSel_PC4;
                    end else if (is_csr_r) begin
                        o_wrDataSel = WrDataSel_CSR;
                    end else if (is_load_r) begin
                        o_wrDataSel = WrDataSel_MEM;
                    end else begin
                        o_wrDataSel = WrDataSel_ALU;
                    end
                    if (is_jal_r) begin
                        o_pcSel = PcSel_Offset;
                    end else if (is_jalr_r) begin
                        o_pcSel = PcSel_Reg;
                    end else begin
                        o_pcSel = PcSel_Next;
                    end
                end
                CtrlState_Trap: begin
                    o_trap      = 1'b1;
                    o_pcUpdate  = 1'b1;
                    o_pcSel     = PcSel_Trap;
                    o_trapCause = cause_r;
                end
                default: begin
                    o_trap = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a per-instruction cycle-trace model built from the
// instruction's class and bus wait counts, checked against the DUT every cycle.
module tb_core_sequencer;

    localparam int TMO = 15;

    typedef struct packed {
        logic [2:0] state;
        logic       ibus_rd;
        logic       inst_load;
        logic       dbus_rd;
        logic       dbus_wr;
        logic       reg_wr;
        logic [1:0] wr_sel;
        logic       csr_wr;
        logic       pc_update;
        logic [1:0] pc_sel;
        logic       trap;
        logic [3:0] cause;
    } rec_t;

    typedef struct packed {
        logic ir;
        logic dr;
    } stim_t;

    typedef struct packed {
        logic [6:0] op;
        logic       ill;
        logic       alu;
        logic       ecall;
        logic       ebreak;
        logic       csr;
    } inst_t;

    localparam inst_t I_ADDI  = {7'h13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam inst_t I_LUI   = {7'h37, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam inst_t I_AUIPC = {7'h17, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam inst_t I_JAL   = {7'h6F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam inst_t I_JALR  = {7'h67, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam inst_t I_CSR   = {7'h73, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam inst_t I_LW    = {7'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam inst_t I_SW    = {7'h23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam inst_t I_BEQ   = {7'h63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam inst_t I_ILL   = {7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam inst_t I_EBRK  = {7'h73, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam inst_t I_ECALL = {7'h73, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam inst_t I_ALLF  = {7'h73, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam inst_t I_EBEC  = {7'h73, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic [6:0] i_instOP;
    logic       i_isIllegal, i_isALU, i_isECALL, i_isEBREAK, i_isCSR;
    logic       i_branchTaken, i_ibusReady, i_dbusReady;
    logic       o_ibusRd, o_instLoad, o_dbusRd, o_dbusWr, o_regWrEnable;
    logic [1:0] o_wrDataSel;
    logic       o_csrWr, o_pcUpdate;
    logic [1:0] o_pcSel;
    logic       o_trap;
    logic [3:0] o_trapCause;
    logic [2:0] o_state;

    core_sequencer #(.BUS_TIMEOUT(TMO)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_instOP(i_instOP),
        .i_isIllegal(i_isIllegal), .i_isALU(i_isALU), .i_isECALL(i_isECALL),
        .i_isEBREAK(i_isEBREAK), .i_isCSR(i_isCSR), .i_branchTaken(i_branchTaken),
        .i_ibusReady(i_ibusReady), .i_dbusReady(i_dbusReady),
        .o_ibusRd(o_ibusRd), .o_instLoad(o_instLoad), .o_dbusRd(o_dbusRd),
        .o_dbusWr(o_dbusWr), .o_regWrEnable(o_regWrEnable), .o_wrDataSel(o_wrDataSel),
        .o_csrWr(o_csrWr), .o_pcUpdate(o_pcUpdate), .o_pcSel(o_pcSel),
        .o_trap(o_trap), .o_trapCause(o_trapCause), .o_state(o_state)
    );

    always #5 i_clock = ~i_clock;

    rec_t  exp_q[$];
    stim_t stim_q[$];
    string pin_name_q[$];
    int    pin_got_q[$];
    int    pin_want_q[$];

    rec_t  cur_exp;
    string cur_name;
    logic  chk_en;
    rec_t  act;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    nrd;

    // The single checker: model pins queued by the driver, then the DUT against the expected trace
    always @(negedge i_clock) begin
        while (pin_name_q.size() > 0) begin
            string n;
            int g, w;
            n = pin_name_q.pop_front();
            g = pin_got_q.pop_front();
            w = pin_want_q.pop_front();
            total++;
            if (g != w) begin
                bad++;
                $display("FAIL %s got=%0d want=%0d", n, g, w);
            end
        end
        if (chk_en) begin
            act = {o_state, o_ibusRd, o_instLoad, o_dbusRd, o_dbusWr, o_regWrEnable,
                   o_wrDataSel, o_csrWr, o_pcUpdate, o_pcSel, o_trap, o_trapCause};
            total++;
            if (act !== cur_exp) begin
                bad++;
                $display("FAIL %s cycle=%0d got=%p want=%p", cur_name, cyc, act, cur_exp);
            end
        end
        cyc++;
    end

    task automatic pin(input string name, input int got, input int want);
        pin_name_q.push_back(name);
        pin_got_q.push_back(got);
        pin_want_q.push_back(want);
    endtask

    task automatic push(input rec_t r, input logic ir, input logic dr);
        stim_t s;
        s.ir = ir;
        s.dr = dr;
        exp_q.push_back(r);
        stim_q.push_back(s);
    endtask

    // Expected cycle trace of one instruction from its class and the bus wait counts
    task automatic plan(input inst_t in, input int fwait, input int mwait, input logic taken);
        rec_t r;
        logic go, ld, st, br, jal, jalr, wb;
        ld   = (in.op == 7'h03);
        st   = (in.op == 7'h23);
        br   = (in.op == 7'h63);
        jal  = (in.op == 7'h6F);
        jalr = (in.op == 7'h67);
        wb   = jal | jalr | (in.op == 7'h37) | (in.op == 7'h17) | in.alu | in.csr;
        go   = 1'b1;
        for (int c = 0; c <= fwait && c <= TMO; c++) begin
            r = '0;
            r.ibus_rd   = 1'b1;
            r.inst_load = (c == fwait);
            push(r, (c == fwait), 1'b0);
        end
        if (fwait > TMO) begin
            r = '0; r.state = 3'd5; r.trap = 1'b1; r.pc_update = 1'b1; r.pc_sel = 2'd3; r.cause = 4'd1;
            push(r, 1'b0, 1'b0);
            go = 1'b0;
        end
        if (go) begin
            r = '0; r.state = 3'd1;
            push(r, 1'b0, 1'b0);
            if (in.ill | in.ebreak | in.ecall) begin
                r = '0; r.state = 3'd5; r.trap = 1'b1; r.pc_update = 1'b1; r.pc_sel = 2'd3;
                r.cause = in.ill ? 4'd2 : (in.ebreak ? 4'd3 : 4'd11);
                push(r, 1'b0, 1'b0);
                go = 1'b0;
            end
        end
        if (go) begin
            r = '0; r.state = 3'd2;
            if (br) begin
                r.pc_update = 1'b1;
                r.pc_sel    = taken ? 2'd1 : 2'd0;
                go = 1'b0;
            end else if (!(ld | st | wb)) begin
                r.pc_update = 1'b1;
                go = 1'b0;
            end
            push(r, 1'b0, 1'b0);
        end
        if (go && (ld || st)) begin
            for (int c = 0; c <= mwait && c <= TMO; c++) begin
                r = '0; r.state = 3'd3; r.dbus_rd = ld; r.dbus_wr = st;
                r.pc_update = st && (c == mwait);
                push(r, 1'b0, (c == mwait));
            end
            if (mwait > TMO) begin
                r = '0; r.state = 3'd5; r.trap = 1'b1; r.pc_update = 1'b1; r.pc_sel = 2'd3;
                r.cause = ld ? 4'd5 : 4'd7;
                push(r, 1'b0, 1'b0);
                go = 1'b0;
            end else if (st) begin
                go = 1'b0;
            end
        end
        if (go) begin
            r = '0; r.state = 3'd4; r.reg_wr = 1'b1; r.pc_update = 1'b1; r.csr_wr = in.csr;
            r.wr_sel = (jal | jalr) ? 2'd2 : (in.csr ? 2'd3 : (ld ? 2'd1 : 2'd0));
            r.pc_sel = jal ? 2'd1 : (jalr ? 2'd2 : 2'd0);
            push(r, 1'b0, 1'b0);
        end
    endtask

    task automatic prep(input inst_t in, input int fwait, input int mwait, input logic taken);
        i_instOP    = in.op;
        i_isIllegal = in.ill;
        i_isALU     = in.alu;
        i_isECALL   = in.ecall;
        i_isEBREAK  = in.ebreak;
        i_isCSR     = in.csr;
        i_branchTaken = taken;
        plan(in, fwait, mwait, taken);
    endtask

    // Play n queued cycles (all when n < 0), then drop whatever is left
    task automatic run(input string name, input int n);
        int k;
        k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            stim_t s;
            cur_exp = exp_q.pop_front();
            s = stim_q.pop_front();
            i_ibusReady = s.ir;
            i_dbusReady = s.dr;
            cur_name = name;
            chk_en = 1'b1;
            @(posedge i_clock);
            #1;
            k++;
        end
        exp_q.delete();
        stim_q.delete();
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            i_reset = 1'b1;
            i_ibusReady = 1'b0;
            i_dbusReady = 1'b0;
            cur_exp = '0;
            cur_name = "reset";
            chk_en = 1'b1;
            @(posedge i_clock);
            #1;
        end
        i_reset = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_instOP = 7'd0; i_isIllegal = 1'b0; i_isALU = 1'b0;
        i_isECALL = 1'b0; i_isEBREAK = 1'b0; i_isCSR = 1'b0; i_branchTaken = 1'b0;
        i_ibusReady = 1'b0; i_dbusReady = 1'b0;
        chk_en = 1'b0; cur_exp = '0; cur_name = "idle";
        @(posedge i_clock);
        #1;
        do_reset(2);

        prep(I_ADDI, 0, 0, 1'b0);
        pin("addi_cycles", exp_q.size(), 4);
        pin("addi_wb_state", int'(exp_q[3].state), 4);
        pin("addi_wb_regwr", int'(exp_q[3].reg_wr), 1);
        run("addi", -1);
        prep(I_LUI, 0, 0, 1'b0);   run("lui", -1);
        prep(I_AUIPC, 2, 0, 1'b0); run("auipc_wait2", -1);
        prep(I_JAL, 0, 0, 1'b0);
        pin("jal_pcsel", int'(exp_q[3].pc_sel), 1);
        pin("jal_wrsel", int'(exp_q[3].wr_sel), 2);
        run("jal", -1);
        prep(I_JALR, 1, 0, 1'b0);  run("jalr", -1);
        prep(I_CSR, 0, 0, 1'b0);   run("csr", -1);

        prep(I_LW, 0, 3, 1'b0);
        nrd = 0;
        foreach (exp_q[k]) if (exp_q[k].dbus_rd) nrd++;
        pin("lw3_cycles", exp_q.size(), 8);
        pin("lw3_dbusrd_cycles", nrd, 4);
        pin("lw3_wrsel", int'(exp_q[7].wr_sel), 1);
        run("lw_wait3", -1);
        prep(I_LW, 0, 0, 1'b0);
        pin("lw_cycles", exp_q.size(), 5);
        run("lw", -1);
        prep(I_SW, 0, 0, 1'b0);
        pin("sw_cycles", exp_q.size(), 4);
        run("sw", -1);
        prep(I_SW, 1, 2, 1'b0);    run("sw_waits", -1);

        prep(I_BEQ, 0, 0, 1'b1);
        pin("beq_cycles", exp_q.size(), 3);
        pin("beq_taken_pcsel", int'(exp_q[2].pc_sel), 1);
        run("beq_taken", -1);
        prep(I_BEQ, 0, 0, 1'b0);   run("beq_not_taken", -1);

        prep(I_ILL, 0, 0, 1'b0);
        pin("ill_cycles", exp_q.size(), 3);
        pin("ill_cause", int'(exp_q[2].cause), 2);
        run("illegal", -1);
        prep(I_EBRK, 0, 0, 1'b0);  run("ebreak", -1);
        prep(I_ECALL, 0, 0, 1'b0);
        pin("ecall_cause", int'(exp_q[2].cause), 11);
        run("ecall", -1);
        prep(I_ALLF, 0, 0, 1'b0);
        pin("prio_all_cause", int'(exp_q[2].cause), 2);
        run("prio_all", -1);
        prep(I_EBEC, 0, 0, 1'b0);
        pin("prio_ebrk_cause", int'(exp_q[2].cause), 3);
        run("prio_ebreak_ecall", -1);

        prep(I_ADDI, 99, 0, 1'b0);
        pin("ifetch_tmo_cycles", exp_q.size(), 17);
        pin("ifetch_tmo_cause", int'(exp_q[16].cause), 1);
        run("ifetch_timeout", -1);
        prep(I_ADDI, TMO, 0, 1'b0);
        pin("ifetch_last_chance_cycles", exp_q.size(), 19);
        run("ifetch_ready_at_limit", -1);
        prep(I_LW, 0, 99, 1'b0);
        pin("lw_tmo_cycles", exp_q.size(), 20);
        pin("lw_tmo_cause", int'(exp_q[19].cause), 5);
        run("load_timeout", -1);
        prep(I_SW, 0, 99, 1'b0);   run("store_timeout", -1);
        prep(I_SW, 0, TMO, 1'b0);  run("store_ready_at_limit", -1);

        prep(I_SW, 0, 99, 1'b0);
        run("sw_before_reset", 5);
        do_reset(1);
        prep(I_ADDI, 0, 0, 1'b0);  run("after_mem_reset", -1);

        prep(I_ADDI, 99, 0, 1'b0);
        run("fetch_before_reset", 10);
        do_reset(1);
        prep(I_ADDI, 99, 0, 1'b0); run("fetch_timeout_after_reset", -1);

        chk_en = 1'b0;
        @(negedge i_clock);
        @(negedge i_clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
